// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, canonical NOP, fetch FSM state
// and the entry format held in the fetch buffer.
package riscv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        StRun,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry circular FIFO with synchronous flush.
// Push when full is ignored; pop when empty is ignored.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_pop    = pop && !empty;
    assign do_push   = push && ((count_q != CntW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: in-order request/response front end with redirect handling.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets via id_fault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] pc_reg
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic            id_fault
`endif
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] target;
    logic [CntW-1:0] outstanding_q;
    logic [CntW-1:0] out_next;
    logic [CntW-1:0] fifo_count;
    logic [CntW-1:0] free_slots;
    logic            stall;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [$bits(fetch_entry_t)-1:0] head_bits;

`ifdef IF_MISALIGN_TRAP_EN
    logic fault_pend_q;
    logic fault_stall_q;
    logic misalign;

    assign target   = redirect_pc;
    assign misalign = redirect_pc[1:0] != 2'b00;
    assign stall    = fault_stall_q;
`else
    assign target = redirect_pc & ~XLEN'(3);
    assign stall  = 1'b0;
`endif

    // Only issue when every in-flight response is guaranteed a buffer slot.
    assign free_slots     = Depth - fifo_count;
    assign imem_req_valid = !rst && (state_q == StRun) && !redirect_valid && !stall &&
                            (free_slots > outstanding_q);
    assign imem_req_addr  = pc_q;
    assign pc_reg         = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign out_next       = outstanding_q + CntW'(accept) - CntW'(imem_rsp_valid);

    assign push       = imem_rsp_valid && (state_q == StRun) && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign pop        = id_ready && !fifo_empty;
    assign head_entry = head_bits;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        id_valid = !fifo_empty;
        id_pc    = '0;
        id_instr = '0;
        if (!fifo_empty) begin
            id_pc    = head_entry.pc;
            id_instr = head_entry.instr;
        end
`ifdef IF_MISALIGN_TRAP_EN
        id_fault = 1'b0;
        if (fault_pend_q) begin
            id_valid = 1'b1;
            id_pc    = pc_q;
            id_instr = NOP_INSTR;
            id_fault = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
            fault_pend_q  <= 1'b0;
            fault_stall_q <= 1'b0;
`endif
        end else begin
            outstanding_q <= out_next;
            if (redirect_valid) begin
                pc_q     <= target;
                rsp_pc_q <= target;
                // Anything still in flight after this edge belongs to the old path.
                if (state_q == StDrain || out_next != '0) state_q <= StDrain;
                else                                        state_q <= StRun;
            end else begin
                if (accept) pc_q     <= pc_q + 32'd4;
                if (push)   rsp_pc_q <= rsp_pc_q + 32'd4;
                if (state_q == StDrain && out_next == '0) state_q <= StRun;
            end
`ifdef IF_MISALIGN_TRAP_EN
            if (redirect_valid) begin
                fault_pend_q  <= misalign;
                fault_stall_q <= misalign;
            end else if (fault_pend_q && id_ready) begin
                fault_pend_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then randomized traffic
// against a transaction-level model (expected PC stream, in-order memory queue).
module tb_instr_fetch;

    localparam int BufDepth = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] pc_reg;
`ifdef IF_MISALIGN_TRAP_EN
    logic        id_fault;
`endif

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (BufDepth)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .pc_reg         (pc_reg)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .id_fault       (id_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory model: in-order queue of accepted addresses with due cycles.
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          last_due;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          idr_pct = 100;

    // Reference model state.
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          stale_left;
    logic [31:0] acc_log[$];
    logic [31:0] post_pcs[$];
    int          first_acc;
    int          first_idv;
    int          pops;
    bit          prev_pending;
    logic [31:0] prev_addr;
    bit          prev_redir_clean;
    bit          fault_exp;
    bit          fault_popped;
    logic [31:0] fault_tgt;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        q_addr.delete();
        q_due.delete();
        acc_log.delete();
        post_pcs.delete();
        last_due         = cyc;
        exp_pc           = 32'h0;
        exp_fetch        = 32'h0;
        stale_left       = 0;
        first_acc        = -1;
        first_idv        = -1;
        prev_pending     = 1'b0;
        prev_redir_clean = 1'b0;
        fault_exp        = 1'b0;
        fault_popped     = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc_reg", pc_reg, 32'h0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_instr", id_instr, 0);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_id_fault", id_fault, 0);
`endif
        clear_model();
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs after the edge, sample and score before the next.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit          rsp_now;
        int          due;
        logic [31:0] a_tgt;
        @(posedge clk);
        #1;
        cyc++;
        rsp_now = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(q_addr[0]);
            q_addr.delete(0);
            q_due.delete(0);
            rsp_now = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        if (prev_pending && imem_req_valid) check("req_addr_hold", imem_req_addr, prev_addr);
        if (stale_left > 0) check("drain_no_req", imem_req_valid, 0);
        if (rsp_now && stale_left > 0) stale_left--;
        if (prev_redir_clean) check("redirect_drops_idv", id_valid, 0);
        if (id_valid && first_idv < 0) first_idv = cyc;
`ifdef IF_MISALIGN_TRAP_EN
        if (fault_exp) check("fault_no_req", imem_req_valid, 0);
        if (fault_exp && fault_popped) check("fault_stall_idv", id_valid, 0);
`endif
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            q_addr.push_back(imem_req_addr);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_due.push_back(due);
            acc_log.push_back(imem_req_addr);
            if (first_acc < 0) first_acc = cyc;
            check("inflight_max", 32'(q_addr.size() <= BufDepth), 1);
        end
        if (id_valid && id_ready) begin
            pops++;
`ifdef IF_MISALIGN_TRAP_EN
            if (fault_exp) begin
                check("fault_pc", id_pc, fault_tgt);
                check("fault_instr", id_instr, 32'h0000_0013);
                check("fault_flag", id_fault, 1);
                fault_popped = 1'b1;
            end else begin
                check("id_pc", id_pc, exp_pc);
                check("id_instr", id_instr, instr_of(exp_pc));
                check("id_fault_clear", id_fault, 0);
                exp_pc = exp_pc + 32'd4;
            end
`else
            check("id_pc", id_pc, exp_pc);
            check("id_instr", id_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
`endif
            post_pcs.push_back(id_pc);
        end
        prev_redir_clean = 1'b0;
        if (redir) begin
`ifdef IF_MISALIGN_TRAP_EN
            a_tgt            = tgt;
            fault_exp        = (tgt[1:0] != 2'b00);
            fault_popped     = 1'b0;
            fault_tgt        = tgt;
            prev_redir_clean = !fault_exp;
`else
            a_tgt            = {tgt[31:2], 2'b00};
            prev_redir_clean = 1'b1;
`endif
            exp_pc     = a_tgt;
            exp_fetch  = a_tgt;
            stale_left = q_addr.size();
            post_pcs.delete();
        end
        prev_pending = imem_req_valid && !imem_req_ready;
        prev_addr    = imem_req_addr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic [31:0] t;
        int          n;
        int          bad;
        int          r;
        pops = 0;
        clear_model();

        // Decode stalled: buffer fills to BufDepth and fetch stops.
        lat_min = 1; lat_max = 1; ready_pct = 100; idr_pct = 0;
        do_reset();
        repeat (10) step(1'b0, '0);
        check("full_accepts", acc_log.size(), BufDepth);
        check("full_no_req", imem_req_valid, 0);
        check("full_id_valid", id_valid, 1);
        check("full_id_pc", id_pc, 32'h0);

        // Reset release, always-ready 1-cycle memory, decode always ready.
        idr_pct = 100;
        do_reset();
        repeat (8) step(1'b0, '0);
        check("acc0", acc_log[0], 32'h0);
        check("acc1", acc_log[1], 32'h4);
        check("acc2", acc_log[2], 32'h8);
        check("first_latency", first_idv - first_acc, 2);

        // Memory back-pressure: address and pc_reg hold.
        ready_pct = 0;
        step(1'b0, '0);
        saved = pc_reg;
        repeat (5) begin
            step(1'b0, '0);
            check("stall_pc_reg", pc_reg, saved);
        end
        check("stall_req_valid", imem_req_valid, 1);
        check("stall_req_addr", imem_req_addr, saved);

        // Redirect with two requests in flight.
        ready_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        n = 0;
        while (q_addr.size() != 2 && n < 20) begin
            step(1'b0, '0);
            n++;
        end
        check("two_inflight", q_addr.size(), 2);
        step(1'b1, 32'h0000_0100);
        n = 0;
        while (post_pcs.size() < 3 && n < 40) begin
            step(1'b0, '0);
            n++;
        end
        check("redir_first_pc", post_pcs[0], 32'h0000_0100);
        bad = 0;
        foreach (post_pcs[i]) if (post_pcs[i] < 32'h100) bad++;
        check("redir_no_stale", bad, 0);

        // PC wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        step(1'b1, 32'hFFFF_FFFC);
        n = 0;
        while (post_pcs.size() < 2 && n < 40) begin
            step(1'b0, '0);
            n++;
        end
        check("wrap_pc0", post_pcs[0], 32'hFFFF_FFFC);
        check("wrap_pc1", post_pcs[1], 32'h0000_0000);

`ifdef IF_MISALIGN_TRAP_EN
        // Misaligned redirect traps with a NOP entry and stops fetching.
        idr_pct = 0;
        step(1'b1, 32'h0000_0102);
        step(1'b0, '0);
        check("mis_id_valid", id_valid, 1);
        check("mis_id_fault", id_fault, 1);
        check("mis_id_instr", id_instr, 32'h0000_0013);
        check("mis_id_pc", id_pc, 32'h0000_0102);
        check("mis_no_req", imem_req_valid, 0);
        repeat (3) step(1'b0, '0);
        idr_pct = 100;
        repeat (4) step(1'b0, '0);
        check("mis_popped", fault_popped, 1);
        step(1'b1, 32'h0000_0200);
`endif

        // Randomized traffic with random latency, back-pressure and redirects.
        lat_min = 1; lat_max = 4; ready_pct = 70; idr_pct = 60;
        n = pops;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(99));
            if (r < 3) begin
                t = $urandom;
                if (r == 0) t = 32'hFFFF_FFF0 | {28'h0, t[3:0]};
`ifdef IF_MISALIGN_TRAP_EN
                t[1:0] = 2'b00;
`endif
                step(1'b1, t);
            end else begin
                step(1'b0, '0);
            end
        end
        check("random_progress", 32'(pops - n > 200), 1);

        // Reset mid-operation, then normal fetch resumes from RESET_PC.
        do_reset();
        ready_pct = 100; idr_pct = 100; lat_min = 1; lat_max = 2;
        repeat (20) step(1'b0, '0);
        check("post_reset_first", acc_log[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
